// File: rtl/data_memory_sized.sv
// ---------------------------------------------------------------------------
// data_memory_sized
//
// Byte-addressed data memory for the MEM stage of the pipeline. Supports
// byte / halfword / word loads and stores (little-endian), sign or zero
// extension of sub-word loads, alignment and range checking, a selectable
// read latency of 0 (combinational) or 1 (registered) cycles, an optional
// hardware clear sequence after reset and a saturating fault counter.
//
// Parameters:
//   ADDR_WIDTH    width of the byte address
//   DEPTH_WORDS   number of 32-bit words stored (2 .. 2^(ADDR_WIDTH-2))
//   READ_LATENCY  0 = combinational read, 1 = registered read
//   INIT_ON_RESET 1 = zero every word after reset, 0 = contents untouched
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   read           load request
//   write          store request
//   size           00 byte, 01 half, 10 word, 11 reserved (always faults)
//   load_unsigned  1 = zero-extend sub-word loads, 0 = sign-extend
//   address        byte address
//   write_data     store data, low 8/16/32 bits used
//   read_data      load result
//   read_valid     read_data holds a completed load
//   ready          memory accepts requests
//   misaligned     current / returned access is misaligned or uses size 11
//   out_of_range   current / returned access has word index >= DEPTH_WORDS
//   fault_count    saturating count of accepted faulting requests
// ---------------------------------------------------------------------------
module data_memory_sized #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 64,
  parameter int READ_LATENCY  = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  ready,
  output logic                  misaligned,
  output logic                  out_of_range,
  output logic [7:0]            fault_count
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // One extra bit so DEPTH_WORDS == 2^(ADDR_WIDTH-2) is still representable.
  localparam logic [ADDR_WIDTH-2:0] DEPTH_LIMIT = (ADDR_WIDTH-1)'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]      LAST_INDEX  = IDX_W'(DEPTH_WORDS - 1);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  // -------------------------------------------------------------------------
  // Storage and control state
  // -------------------------------------------------------------------------
  logic [31:0]           mem [DEPTH_WORDS];
  state_t                state;
  logic [IDX_W-1:0]      clear_index;
  logic                  ready_reg;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-3:0] word_index;
  logic [IDX_W-1:0]      mem_index;
  logic                  misaligned_now;
  logic                  out_of_range_now;
  logic                  fault_now;
  logic                  accept;
  logic                  load_accept;
  logic                  store_en;
  logic                  clear_we;
  logic [3:0]            lane_mask;
  logic [31:0]           store_word;
  logic [31:0]           mem_word;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           extracted;
  logic [31:0]           load_result;

  assign word_index = address[ADDR_WIDTH-1:2];
  assign mem_index  = word_index[IDX_W-1:0];

  // The registered ready is additionally masked by reset so the memory never
  // advertises itself as ready while reset is being applied.
  assign ready = ready_reg && !reset;

  assign accept      = ready && (read || write);
  assign load_accept = ready && read;

  always_comb begin
    misaligned_now = 1'b0;
    case (size)
      SIZE_BYTE: misaligned_now = 1'b0;
      SIZE_HALF: misaligned_now = address[0];
      SIZE_WORD: misaligned_now = (address[1:0] != 2'b00);
      default:   misaligned_now = 1'b1;
    endcase
  end

  assign out_of_range_now = ({1'b0, word_index} >= DEPTH_LIMIT);
  assign fault_now        = misaligned_now || out_of_range_now;

  // A faulting store never reaches the array; the clear sequence only runs
  // while ready is low, so the two write sources are mutually exclusive.
  assign store_en = ready && write && !fault_now;
  assign clear_we = (state == CLEAR) && !reset;

  // Byte-lane enables and lane-replicated store data: the selected lanes
  // simply pick up their copy of the low byte / halfword.
  always_comb begin
    lane_mask  = 4'b0000;
    store_word = write_data;
    case (size)
      SIZE_BYTE: begin
        lane_mask  = 4'b0001 << address[1:0];
        store_word = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        lane_mask  = address[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
      end
      SIZE_WORD: begin
        lane_mask  = 4'b1111;
        store_word = write_data;
      end
      default: begin
        lane_mask  = 4'b0000;
        store_word = write_data;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load extraction
  // -------------------------------------------------------------------------
  // Out-of-range indices are not looked up so a non-power-of-two depth never
  // reads past the end of the array.
  assign mem_word = out_of_range_now ? 32'h0 : mem[mem_index];

  always_comb begin
    lane_byte = mem_word[7:0];
    case (address[1:0])
      2'b00:   lane_byte = mem_word[7:0];
      2'b01:   lane_byte = mem_word[15:8];
      2'b10:   lane_byte = mem_word[23:16];
      default: lane_byte = mem_word[31:24];
    endcase
  end

  assign lane_half = address[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    extracted = mem_word;
    case (size)
      SIZE_BYTE: extracted = load_unsigned ? {24'h0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
      SIZE_HALF: extracted = load_unsigned ? {16'h0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
      default:   extracted = mem_word;
    endcase
  end

  assign load_result = fault_now ? 32'h0 : extracted;

  // -------------------------------------------------------------------------
  // Clear FSM
  // -------------------------------------------------------------------------
  // CLEAR walks clear_index from 0 to DEPTH_WORDS-1, one word per cycle, and
  // raises ready on the same edge that writes the last word, giving exactly
  // DEPTH_WORDS not-ready cycles after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_index <= '0;
      if (INIT_ON_RESET != 0) begin
        state     <= CLEAR;
        ready_reg <= 1'b0;
      end else begin
        state     <= IDLE;
        ready_reg <= 1'b1;
      end
    end else begin
      case (state)
        CLEAR: begin
          if (clear_index == LAST_INDEX) begin
            state       <= IDLE;
            ready_reg   <= 1'b1;
            clear_index <= '0;
          end else begin
            clear_index <= clear_index + 1'b1;
          end
        end
        IDLE: begin
          ready_reg <= 1'b1;
        end
        default: begin
          state     <= CLEAR;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage array (no reset; zeroing is done by the clear sequence)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_index] <= 32'h0;
    end else if (store_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (lane_mask[lane]) begin
          mem[mem_index][8*lane +: 8] <= store_word[8*lane +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating fault counter; a simultaneous read+write is one event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_count <= 8'h00;
    end else if (accept && fault_now && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'h01;
    end
  end

  // -------------------------------------------------------------------------
  // Result path
  // -------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      // Combinational result; a same-cycle store is only visible after the edge.
      assign read_valid   = load_accept;
      assign read_data    = load_accept ? load_result : 32'h0;
      assign misaligned   = accept && misaligned_now;
      assign out_of_range = accept && out_of_range_now;
    end else begin : g_reg_read
      logic [31:0] data_q;
      logic        valid_q;
      logic        misaligned_q;
      logic        out_of_range_q;

      // Sampling the array before the edge gives read-first behaviour for a
      // same-word store; data holds when no load is accepted.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_q         <= 32'h0;
          valid_q        <= 1'b0;
          misaligned_q   <= 1'b0;
          out_of_range_q <= 1'b0;
        end else begin
          valid_q        <= load_accept;
          misaligned_q   <= accept && misaligned_now;
          out_of_range_q <= accept && out_of_range_now;
          if (load_accept) begin
            data_q <= load_result;
          end
        end
      end

      assign read_valid   = valid_q;
      assign read_data    = data_q;
      assign misaligned   = misaligned_q;
      assign out_of_range = out_of_range_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_sized.sv
// ---------------------------------------------------------------------------
// tb_data_memory_sized
//
// Drives three instances of data_memory_sized from one stimulus stream:
//   u_lat0   READ_LATENCY=0, INIT_ON_RESET=1
//   u_lat1   READ_LATENCY=1, INIT_ON_RESET=1
//   u_noinit READ_LATENCY=0, INIT_ON_RESET=0 (only its ready is compared)
// Expected values come from a byte-array reference model with a countdown
// for the post-reset clear window.
// ---------------------------------------------------------------------------
module tb_data_memory_sized;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;

  logic [31:0] rd0, rd1, rdn;
  logic        rv0, rv1, rvn;
  logic        rdy0, rdy1, rdyn;
  logic        mis0, mis1, misn;
  logic        oor0, oor1, oorn;
  logic [7:0]  fc0, fc1, fcn;

  always #5 clk = ~clk;

  data_memory_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(0), .INIT_ON_RESET(1)) u_lat0 (
    .clk(clk), .reset(reset), .read(read), .write(write), .size(size),
    .load_unsigned(load_unsigned), .address(address), .write_data(write_data),
    .read_data(rd0), .read_valid(rv0), .ready(rdy0), .misaligned(mis0),
    .out_of_range(oor0), .fault_count(fc0)
  );

  data_memory_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .INIT_ON_RESET(1)) u_lat1 (
    .clk(clk), .reset(reset), .read(read), .write(write), .size(size),
    .load_unsigned(load_unsigned), .address(address), .write_data(write_data),
    .read_data(rd1), .read_valid(rv1), .ready(rdy1), .misaligned(mis1),
    .out_of_range(oor1), .fault_count(fc1)
  );

  data_memory_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(0), .INIT_ON_RESET(0)) u_noinit (
    .clk(clk), .reset(reset), .read(read), .write(write), .size(size),
    .load_unsigned(load_unsigned), .address(address), .write_data(write_data),
    .read_data(rdn), .read_valid(rvn), .ready(rdyn), .misaligned(misn),
    .out_of_range(oorn), .fault_count(fcn)
  );

  // Reference model state
  logic [7:0]  model_bytes [DEPTH*4];
  int          clear_left;
  int          model_faults;
  logic [31:0] lat1_hold;

  int          assertions;
  int          failures;

  // Snapshots of the most recent cycle for directed checks
  logic [31:0] last_data0;
  logic        last_valid0;
  logic        last_ready0;
  logic        last_mis0;
  logic        last_oor0;
  logic [31:0] last_data1;
  logic        last_valid1;
  logic [7:0]  last_faults0;
  logic [7:0]  last_faults1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int          n;
    logic [31:0] v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      v = v | (32'(model_bytes[int'(a) + i]) << (8 * i));
    end
    if (!uns && n < 4 && v[8*n-1]) begin
      v = v | (32'hFFFF_FFFF << (8 * n));
    end
    return v;
  endfunction

  // One full clock cycle: drive, check combinational outputs, clock, check
  // registered outputs, then advance the model.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd);
    logic        ready_m, mis_m, oor_m, fault_m, acc_m, valid_m;
    logic [31:0] load_m;

    @(negedge clk);
    reset         = rst;
    read          = rd;
    write         = wr;
    size          = sz;
    load_unsigned = uns;
    address       = a;
    write_data    = wd;
    #1;

    ready_m = !rst && (clear_left == 0);
    mis_m   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    oor_m   = (a >> 2) >= DEPTH;
    fault_m = mis_m || oor_m;
    acc_m   = ready_m && (rd || wr);
    valid_m = ready_m && rd;
    load_m  = (valid_m && !fault_m) ? modelLoad(a, sz, uns) : 32'h0;

    checkOutput("lat0_ready", rdy0, ready_m);
    checkOutput("lat1_ready", rdy1, ready_m);
    checkOutput("noinit_ready", rdyn, !rst);
    checkOutput("lat0_valid", rv0, valid_m);
    checkOutput("lat0_data", rd0, load_m);
    checkOutput("lat0_misaligned", mis0, acc_m && mis_m);
    checkOutput("lat0_out_of_range", oor0, acc_m && oor_m);
    last_data0  = rd0;
    last_valid0 = rv0;
    last_ready0 = rdy0;
    last_mis0   = mis0;
    last_oor0   = oor0;

    @(posedge clk);
    #1;

    if (rst) lat1_hold = 32'h0;
    else if (valid_m) lat1_hold = load_m;
    checkOutput("lat1_valid", rv1, !rst && valid_m);
    checkOutput("lat1_data", rd1, lat1_hold);
    checkOutput("lat1_misaligned", mis1, acc_m && mis_m);
    checkOutput("lat1_out_of_range", oor1, acc_m && oor_m);
    last_data1  = rd1;
    last_valid1 = rv1;

    if (rst) begin
      clear_left   = DEPTH;
      model_faults = 0;
      for (int i = 0; i < DEPTH*4; i++) model_bytes[i] = 8'h00;
    end else begin
      if (clear_left > 0) clear_left--;
      if (acc_m) begin
        if (fault_m) begin
          if (model_faults < 255) model_faults++;
        end else if (wr) begin
          for (int i = 0; i < ((sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4); i++) begin
            model_bytes[int'(a) + i] = wd[8*i +: 8];
          end
        end
      end
    end

    checkOutput("lat0_fault_count", fc0, model_faults);
    checkOutput("lat1_fault_count", fc1, model_faults);
    last_faults0 = fc0;
    last_faults1 = fc1;
  endtask

  task automatic randomCycle(input logic rst);
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom;
    else a = $urandom_range(0, DEPTH*4 - 1);
    applyStimulus(rst, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] plan_bytes [4];
    int          low_count;

    assertions    = 0;
    failures      = 0;
    clear_left    = DEPTH;
    model_faults  = 0;
    lat1_hold     = 32'h0;
    reset         = 1'b1;
    read          = 1'b0;
    write         = 1'b0;
    size          = 2'b00;
    load_unsigned = 1'b0;
    address       = 32'h0;
    write_data    = 32'h0;
    for (int i = 0; i < DEPTH*4; i++) model_bytes[i] = 8'h00;

    plan_bytes[0] = 32'hFFFF_FFEF;
    plan_bytes[1] = 32'hFFFF_FFBE;
    plan_bytes[2] = 32'hFFFF_FFAD;
    plan_bytes[3] = 32'hFFFF_FFDE;

    // Reset, then the clear window with requests that must be ignored
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("reset_fault_count", last_faults0, 0);
    low_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      randomCycle(0);
      if (!last_ready0) low_count++;
    end
    checkOutput("clear_low_cycles", low_count, DEPTH);

    // Directed loads and stores
    applyStimulus(0, 1, 0, 2'b10, 0, 12, 0);
    checkOutput("plan_ready_after_clear", last_ready0, 1);
    checkOutput("plan_read12", last_data0, 32'h0);
    applyStimulus(0, 0, 1, 2'b10, 0, 20, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 2'b00, 0, 20 + i, 0);
      checkOutput("plan_byte_signed", last_data0, plan_bytes[i]);
    end
    applyStimulus(0, 1, 0, 2'b00, 1, 23, 0);
    checkOutput("plan_byte_unsigned", last_data0, 32'h0000_00DE);
    applyStimulus(0, 0, 1, 2'b00, 0, 21, 32'h0000_0055);
    applyStimulus(0, 1, 0, 2'b10, 0, 20, 0);
    checkOutput("plan_byte_merge", last_data0, 32'hDEAD_55EF);
    applyStimulus(0, 0, 1, 2'b01, 0, 22, 32'h0000_1234);
    applyStimulus(0, 1, 0, 2'b10, 0, 20, 0);
    checkOutput("plan_half_merge", last_data0, 32'h1234_55EF);
    applyStimulus(0, 1, 0, 2'b01, 0, 22, 0);
    checkOutput("plan_half_signed", last_data0, 32'h0000_1234);

    // Faults
    applyStimulus(0, 0, 1, 2'b10, 0, 22, 32'hFFFF_FFFF);
    checkOutput("plan_store_misaligned", last_mis0, 1);
    applyStimulus(0, 1, 0, 2'b10, 0, 20, 0);
    checkOutput("plan_unchanged", last_data0, 32'h1234_55EF);
    applyStimulus(0, 1, 0, 2'b01, 0, 21, 0);
    checkOutput("plan_load_misaligned", last_mis0, 1);
    checkOutput("plan_fault_load_data", last_data0, 32'h0);
    checkOutput("plan_fault_load_valid", last_valid0, 1);
    checkOutput("plan_fault_count2", last_faults0, 2);
    applyStimulus(0, 0, 1, 2'b10, 0, 256, 32'h1111_1111);
    checkOutput("plan_out_of_range", last_oor0, 1);
    checkOutput("plan_fault_count3", last_faults0, 3);

    // Read-first on a same-word read+write
    applyStimulus(0, 1, 1, 2'b10, 0, 8, 32'h0000_0001);
    checkOutput("plan_lat1_read_first", last_data1, 32'h0);
    checkOutput("plan_lat1_valid", last_valid1, 1);
    applyStimulus(0, 1, 0, 2'b10, 0, 8, 0);
    checkOutput("plan_lat1_new_data", last_data1, 32'h0000_0001);

    // Randomised traffic
    for (int i = 0; i < 500; i++) randomCycle(0);

    // Reset in the middle of the clear sequence
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 30; i++) randomCycle(0);
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0);
    low_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      randomCycle(0);
      if (!last_ready0) low_count++;
    end
    checkOutput("restart_low_cycles", low_count, DEPTH);

    // Saturation of the fault counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), 2'b11, 0, $urandom_range(0, DEPTH*4 - 1), $urandom);
    end
    checkOutput("saturate_lat0", last_faults0, 255);
    checkOutput("saturate_lat1", last_faults1, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
